microcode_sequencer: RTL and testbench

Fetches microcode words from `microcode_rom` one instruction at a time, decodes them, and issues gate commands to the downstream gate engine over a valid/ready handshake. It consumes the ROM encoding: op[31:28], target[27:24], aux[23:20], imm[19:4]. It sits between the host control registers (start / prog select) and the state-vector gate engine. It reports completion, gate count and decode errors.

---
 rtl/qc_isa_pkg.sv | 54 +++++
 rtl/microcode_decoder.sv | 54 +++++
 rtl/microcode_sequencer.sv | 156 +++++++++++++++
 tb/tb_microcode_sequencer.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qc_isa_pkg.sv
// qc_isa_pkg: microcode ISA shared by the ROM, decoder and sequencer.
// Word layout: op[31:28] target[27:24] aux[23:20] imm[19:4], bits [3:0] reserved.
package qc_isa_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_H      = 4'd1,
        OP_X      = 4'd2,
        OP_Z      = 4'd3,
        OP_CNOT   = 4'd4,
        OP_CPHASE = 4'd5,
        OP_SWAP   = 4'd6,
        OP_END    = 4'd15
    } opcode_e;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int TGT_MSB = 27;
    localparam int TGT_LSB = 24;
    localparam int AUX_MSB = 23;
    localparam int AUX_LSB = 20;
    localparam int IMM_MSB = 19;
    localparam int IMM_LSB = 4;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_ILLEGAL_OP = 2'd1,
        ERR_BAD_QUBIT  = 2'd2,
        ERR_NO_END     = 2'd3
    } err_code_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  target;
        logic [3:0]  aux;
        logic [15:0] imm;
    } gate_cmd_t;

    // Opcodes 1..6 are gates issued to the engine.
    function automatic logic is_gate_op(input logic [3:0] op);
        return (op >= OP_H) && (op <= OP_SWAP);
    endfunction

    // Gates that use aux as a second qubit operand.
    function automatic logic is_two_qubit_op(input logic [3:0] op);
        return (op == OP_CNOT) || (op == OP_CPHASE) || (op == OP_SWAP);
    endfunction

    // Opcodes 7..14 have no meaning and abort the run.
    function automatic logic is_illegal_op(input logic [3:0] op);
        return (op >= 4'd7) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/microcode_decoder.sv
// microcode_decoder: purely combinational split and validation of one ROM word.
module microcode_decoder
    import qc_isa_pkg::*;
#(
    parameter int NUM_QUBITS = 4
) (
    input  logic [31:0] i_rom_data,
    output gate_cmd_t   o_cmd,
    output logic        o_is_end,
    output logic        o_is_nop,
    output err_code_e   o_err_code
);

    // One extra bit so that NUM_QUBITS up to 16 still compares correctly.
    localparam logic [4:0] LP_NQ = 5'(NUM_QUBITS);

    logic [3:0]  w_op;
    logic [3:0]  w_tgt;
    logic [3:0]  w_aux;
    logic [15:0] w_imm;
    logic        w_tgt_bad;
    logic        w_aux_bad;
    logic        unused_low_bits;

    assign w_op  = i_rom_data[OP_MSB:OP_LSB];
    assign w_tgt = i_rom_data[TGT_MSB:TGT_LSB];
    assign w_aux = i_rom_data[AUX_MSB:AUX_LSB];
    assign w_imm = i_rom_data[IMM_MSB:IMM_LSB];

    // The low nibble is reserved in the encoding and carries nothing.
    assign unused_low_bits = ^i_rom_data[IMM_LSB-1:0];

    assign w_tgt_bad = ({1'b0, w_tgt} >= LP_NQ);
    assign w_aux_bad = ({1'b0, w_aux} >= LP_NQ) || (w_aux == w_tgt);

    // Classify the word and flag illegal opcodes or out-of-range qubit operands.
    always_comb begin
        o_cmd.op     = w_op;
        o_cmd.target = w_tgt;
        o_cmd.aux    = w_aux;
        o_cmd.imm    = w_imm;
        o_is_end     = (w_op == OP_END);
        o_is_nop     = (w_op == OP_NOP);
        o_err_code   = ERR_NONE;
        if (is_illegal_op(w_op)) begin
            o_err_code = ERR_ILLEGAL_OP;
        end else if (is_gate_op(w_op)) begin
            if (w_tgt_bad || (is_two_qubit_op(w_op) && w_aux_bad)) begin
                o_err_code = ERR_BAD_QUBIT;
            end
        end
    end

endmodule

// File: rtl/microcode_sequencer.sv
// microcode_sequencer: walks a microcode program in ROM, issues each legal gate
// over a valid/ready handshake and reports done / error / gate count.
module microcode_sequencer
    import qc_isa_pkg::*;
#(
    parameter int NUM_QUBITS = 4,
    parameter int MAX_ADDR   = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  prog_id,
    output logic [1:0]  rom_prog_id,
    output logic [7:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic        gate_valid,
    input  logic        gate_ready,
    output logic [3:0]  gate_op,
    output logic [3:0]  gate_target,
    output logic [3:0]  gate_aux,
    output logic [15:0] gate_imm,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [8:0]  gate_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] LP_MAX_ADDR = 8'(MAX_ADDR);

    state_e    r_state;
    logic [1:0] r_prog_id;
    logic [7:0] r_addr;
    gate_cmd_t r_cmd;
    logic      r_gate_valid;
    logic      r_busy;
    logic      r_done;
    logic      r_err;
    err_code_e r_err_code;
    logic [8:0] r_count;

    gate_cmd_t w_cmd;
    logic      w_is_end;
    logic      w_is_nop;
    err_code_e w_dec_err;

    microcode_decoder #(
        .NUM_QUBITS (NUM_QUBITS)
    ) u_decoder (
        .i_rom_data (rom_data),
        .o_cmd      (w_cmd),
        .o_is_end   (w_is_end),
        .o_is_nop   (w_is_nop),
        .o_err_code (w_dec_err)
    );

    // Sequencer FSM: program counter, gate handshake and run status; every output is registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_prog_id    <= '0;
            r_addr       <= '0;
            r_cmd        <= '0;
            r_gate_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_count      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_prog_id  <= prog_id;
                        r_addr     <= '0;
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_err_code <= ERR_NONE;
                        r_busy     <= 1'b1;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (w_is_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_is_nop) begin
                        // A NOP on the last address means the program ran off the ROM.
                        if (r_addr == LP_MAX_ADDR) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_NO_END;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_addr <= r_addr + 8'd1;
                        end
                    end else if (w_dec_err != ERR_NONE) begin
                        r_err      <= 1'b1;
                        r_err_code <= w_dec_err;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_cmd        <= w_cmd;
                        r_gate_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Command fields stay frozen until the engine takes them.
                    if (r_gate_valid && gate_ready) begin
                        r_gate_valid <= 1'b0;
                        r_count      <= r_count + 9'd1;
                        if (r_addr == LP_MAX_ADDR) begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_NO_END;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_addr  <= r_addr + 8'd1;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rom_prog_id = r_prog_id;
    assign rom_addr    = r_addr;
    assign gate_valid  = r_gate_valid;
    assign gate_op     = r_cmd.op;
    assign gate_target = r_cmd.target;
    assign gate_aux    = r_cmd.aux;
    assign gate_imm    = r_cmd.imm;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign gate_count  = r_count;

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb_microcode_sequencer: ROM model, reference program walker and scoreboard
// for microcode_sequencer.
`timescale 1ns/1ps
module tb_microcode_sequencer;

    localparam int NQ = 4;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  t;
        logic [3:0]  a;
        logic [15:0] imm;
    } exp_gate_t;

    typedef struct packed {
        logic [1:0] code;
        logic [8:0] count;
    } exp_res_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  prog_id;
    logic [1:0]  rom_prog_id;
    logic [7:0]  rom_addr;
    logic [31:0] rom_data;
    logic        gate_valid;
    logic        gate_ready;
    logic [3:0]  gate_op;
    logic [3:0]  gate_target;
    logic [3:0]  gate_aux;
    logic [15:0] gate_imm;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [8:0]  gate_count;

    logic [31:0] rom_mem [0:3][0:255];

    exp_gate_t exp_q[$];
    exp_res_t  res_q[$];
    int        hs_cyc[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int ready_mode = 0;

    logic        hold_vld = 1'b0;
    logic [27:0] hold_val;
    logic [27:0] mon_act;
    exp_gate_t   mon_e;
    exp_res_t    mon_r;

    microcode_sequencer #(
        .NUM_QUBITS (NQ),
        .MAX_ADDR   (255)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .prog_id     (prog_id),
        .rom_prog_id (rom_prog_id),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .gate_valid  (gate_valid),
        .gate_ready  (gate_ready),
        .gate_op     (gate_op),
        .gate_target (gate_target),
        .gate_aux    (gate_aux),
        .gate_imm    (gate_imm),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .gate_count  (gate_count)
    );

    assign rom_data = rom_mem[rom_prog_id][rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // gate_ready: always ready, randomly stalling, or never ready.
    initial begin
        gate_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       gate_ready = 1'b1;
                1:       gate_ready = ($urandom_range(0, 2) != 0);
                default: gate_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // Monitor: checks stall stability, each handshake against the queue and each done pulse.
    always @(negedge clk) begin
        mon_act = {gate_op, gate_target, gate_aux, gate_imm};
        if (!rst_n) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                tests++;
                if (gate_valid !== 1'b1 || mon_act !== hold_val) begin
                    fails++;
                    $display("FAIL stall_hold got vld=%0b cmd=%h exp vld=1 cmd=%h", gate_valid, mon_act, hold_val);
                end
            end
            hold_vld = 1'b0;
            if (gate_valid === 1'b1) begin
                if (gate_ready) begin
                    hs_cyc.push_back(cyc);
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL gate_cmd got %h exp no gate", mon_act);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_act !== mon_e) begin
                            fails++;
                            $display("FAIL gate_cmd got %h exp %h", mon_act, mon_e);
                        end
                    end
                end else begin
                    hold_vld = 1'b1;
                    hold_val = mon_act;
                end
            end
            if (done === 1'b1) begin
                done_seen++;
                done_cyc = cyc;
                tests++;
                if (res_q.size() == 0) begin
                    fails++;
                    $display("FAIL done_pulse got unexpected done exp none");
                end else begin
                    mon_r = res_q.pop_front();
                    if ({err, err_code, gate_count} !== {(mon_r.code != 2'd0), mon_r.code, mon_r.count}) begin
                        fails++;
                        $display("FAIL run_result got err=%0b code=%0d cnt=%0d exp err=%0b code=%0d cnt=%0d",
                                 err, err_code, gate_count, (mon_r.code != 2'd0), mon_r.code, mon_r.count);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] mk(input int op, input int t, input int a, input int imm);
        logic [31:0] w;
        logic [31:0] o32, t32, a32, i32;
        o32 = op; t32 = t; a32 = a; i32 = imm;
        w = {o32[3:0], t32[3:0], a32[3:0], i32[15:0], 4'h0};
        return w;
    endfunction

    function automatic logic [52:0] all_outs();
        return {rom_prog_id, rom_addr, gate_valid, gate_op, gate_target, gate_aux,
                gate_imm, busy, done, err, err_code, gate_count};
    endfunction

    task automatic clear_prog(input int p);
        for (int i = 0; i < 256; i++) rom_mem[p][i] = 32'h0;
    endtask

    task automatic load_std();
        for (int p = 0; p < 4; p++) clear_prog(p);
        // QFT2
        rom_mem[0][0] = mk(1, 1, 0, 0);
        rom_mem[0][1] = mk(5, 0, 1, 2);
        rom_mem[0][2] = mk(1, 0, 0, 0);
        rom_mem[0][3] = mk(6, 0, 1, 0);
        rom_mem[0][4] = mk(15, 0, 0, 0);
        // QFT4
        rom_mem[1][0]  = mk(1, 0, 0, 0);
        rom_mem[1][1]  = mk(5, 1, 0, 2);
        rom_mem[1][2]  = mk(5, 2, 0, 3);
        rom_mem[1][3]  = mk(5, 3, 0, 4);
        rom_mem[1][4]  = mk(1, 1, 0, 0);
        rom_mem[1][5]  = mk(5, 2, 1, 2);
        rom_mem[1][6]  = mk(5, 3, 1, 3);
        rom_mem[1][7]  = mk(1, 2, 0, 0);
        rom_mem[1][8]  = mk(5, 3, 2, 2);
        rom_mem[1][9]  = mk(1, 3, 0, 0);
        rom_mem[1][10] = mk(6, 0, 3, 0);
        rom_mem[1][11] = mk(6, 1, 2, 0);
        rom_mem[1][12] = mk(15, 0, 0, 0);
        // Grover2
        rom_mem[2][0]  = mk(1, 0, 0, 0);
        rom_mem[2][1]  = mk(1, 1, 0, 0);
        rom_mem[2][2]  = mk(0, 0, 0, 0);
        rom_mem[2][3]  = mk(5, 1, 0, 1);
        rom_mem[2][4]  = mk(1, 0, 0, 0);
        rom_mem[2][5]  = mk(1, 1, 0, 0);
        rom_mem[2][6]  = mk(2, 0, 0, 0);
        rom_mem[2][7]  = mk(2, 1, 0, 0);
        rom_mem[2][8]  = mk(5, 1, 0, 1);
        rom_mem[2][9]  = mk(2, 0, 0, 0);
        rom_mem[2][10] = mk(2, 1, 0, 0);
        rom_mem[2][11] = mk(1, 0, 0, 0);
        rom_mem[2][12] = mk(1, 1, 0, 0);
        rom_mem[2][13] = mk(15, 0, 0, 0);
        // Bell
        rom_mem[3][0] = mk(1, 0, 0, 0);
        rom_mem[3][1] = mk(4, 1, 0, 0);
        rom_mem[3][2] = mk(15, 0, 0, 0);
    endtask

    // Reference walker: interprets the program word by word and queues the expected outcome.
    task automatic build_expect(input int p);
        int        a, op, t, x;
        bit        fin;
        logic [31:0] w;
        exp_res_t  r;
        r.code = 2'd0; r.count = 9'd0; fin = 1'b0; a = 0;
        while (!fin) begin
            w  = rom_mem[p][a];
            op = int'(w[31:28]);
            t  = int'(w[27:24]);
            x  = int'(w[23:20]);
            if (op == 15) begin
                fin = 1'b1;
            end else if (op == 0) begin
                if (a == 255) begin r.code = 2'd3; fin = 1'b1; end
                else a++;
            end else if (op >= 7) begin
                r.code = 2'd1; fin = 1'b1;
            end else if (t >= NQ || (op >= 4 && (x >= NQ || x == t))) begin
                r.code = 2'd2; fin = 1'b1;
            end else begin
                exp_q.push_back({w[31:28], w[27:24], w[23:20], w[19:4]});
                r.count = r.count + 9'd1;
                if (a == 255) begin r.code = 2'd3; fin = 1'b1; end
                else a++;
            end
        end
        res_q.push_back(r);
    endtask

    function automatic logic [31:0] rand_word();
        int r, op, t, a;
        r = $urandom_range(0, 39);
        if (r < 4) op = 0;
        else if (r < 6) op = $urandom_range(7, 14);
        else if (r < 7) op = 15;
        else op = $urandom_range(1, 6);
        t = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
        if ($urandom_range(0, 19) == 0) a = $urandom_range(0, 15);
        else a = (t + 1 + $urandom_range(0, 2)) % 4;
        return mk(op, t, a, $urandom_range(0, 65535));
    endfunction

    task automatic rand_prog(input int p);
        int len;
        clear_prog(p);
        len = $urandom_range(1, 24);
        for (int i = 0; i < len; i++) rom_mem[p][i] = rand_word();
        if ($urandom_range(0, 4) != 0) rom_mem[p][len] = mk(15, 0, 0, 0);
    endtask

    task automatic run_prog(input int p, input int mode, output int start_cyc);
        int d0, n;
        build_expect(p);
        ready_mode = mode;
        hs_cyc.delete();
        d0 = done_seen;
        @(posedge clk); #1;
        prog_id = 2'(p);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        n = 0;
        while (done_seen == d0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (done_seen == d0) begin
            fails++;
            $display("FAIL run_timeout prog=%0d got no done exp done", p);
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            exp_q.delete();
            res_q.delete();
        end
        tests++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            fails++;
            $display("FAIL leftover prog=%0d got gates=%0d results=%0d exp 0 0", p, exp_q.size(), res_q.size());
            exp_q.delete();
            res_q.delete();
        end
    endtask

    initial begin
        int s, n, d0;
        rst_n   = 1'b0;
        start   = 1'b0;
        prog_id = 2'd0;
        load_std();
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (all_outs() !== 53'd0) begin
            fails++;
            $display("FAIL reset_outs got %h exp 0", all_outs());
        end
        rst_n = 1'b1;

        // Bell with exact cycle timing.
        run_prog(3, 0, s);
        tests++;
        if (hs_cyc.size() != 2 || hs_cyc[0] != s + 1 || hs_cyc[1] != s + 3) begin
            fails++;
            $display("FAIL bell_hs_timing got n=%0d first=%0d exp n=2 at %0d,%0d",
                     hs_cyc.size(), (hs_cyc.size() > 0) ? hs_cyc[0] - s : -1, 1, 3);
        end
        tests++;
        if (done_cyc != s + 5) begin
            fails++;
            $display("FAIL bell_done_timing got %0d exp 5", done_cyc - s);
        end

        run_prog(1, 1, s);
        run_prog(2, 1, s);
        run_prog(0, 0, s);

        // Illegal opcode after one good gate; err holds afterwards.
        clear_prog(0);
        rom_mem[0][0] = mk(1, 2, 0, 16'h1234);
        rom_mem[0][1] = mk(9, 0, 0, 0);
        run_prog(0, 1, s);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (err !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL err_hold got err=%0b code=%0d busy=%0b exp 1 1 0", err, err_code, busy);
        end

        // Bad qubit operands.
        clear_prog(1);
        rom_mem[1][0] = mk(4, 2, 2, 0);
        run_prog(1, 0, s);
        rom_mem[1][0] = mk(1, 5, 0, 0);
        run_prog(1, 0, s);

        // All NOP: runs the full address space.
        clear_prog(2);
        run_prog(2, 0, s);
        tests++;
        if (done_cyc != s + 256) begin
            fails++;
            $display("FAIL nop_timing got %0d exp 256", done_cyc - s);
        end

        // Gate on the last address.
        clear_prog(3);
        rom_mem[3][255] = mk(2, 3, 0, 16'hBEEF);
        run_prog(3, 1, s);

        load_std();

        // start while busy and in the DONE cycle.
        build_expect(3);
        ready_mode = 0;
        @(posedge clk); #1;
        prog_id = 2'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        prog_id = 2'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        start = 1'b1;
        prog_id = 2'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || rom_prog_id !== 2'd3 || exp_q.size() != 0 || res_q.size() != 0) begin
            fails++;
            $display("FAIL start_ignored got busy=%0b prog=%0d pend=%0d exp busy=0 prog=3 pend=0",
                     busy, rom_prog_id, exp_q.size() + res_q.size());
            exp_q.delete();
            res_q.delete();
        end

        // Randomized programs with random stalls.
        for (int k = 0; k < 30; k++) begin
            rand_prog(2);
            run_prog(2, 1, s);
        end
        load_std();

        // Reset during a stalled ISSUE.
        build_expect(1);
        ready_mode = 2;
        @(posedge clk); #1;
        prog_id = 2'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (gate_valid !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (gate_valid !== 1'b1) begin
            fails++;
            $display("FAIL stall_reach got vld=%0b exp 1", gate_valid);
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        d0 = done_seen;
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests++;
        if (all_outs() !== 53'd0) begin
            fails++;
            $display("FAIL midrun_reset got %h exp 0", all_outs());
        end
        rst_n = 1'b1;
        exp_q.delete();
        res_q.delete();
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (done_seen != d0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_done got dones=%0d busy=%0b exp 0 0", done_seen - d0, busy);
        end

        // Normal run after the abort.
        run_prog(3, 0, s);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
